// File: rtl/sm_loader_pkg.sv
// rtl/sm_loader_pkg.sv - shared constants, state encodings and helpers for the ROM loader
// Contents: default parameter values, loader FSM states, receiver states,
//           byte shift-in helper used for MSB-first word assembly.
package sm_loader_pkg;

    localparam int DEF_CLKS_PER_BIT = 870;
    localparam int DEF_ADDR_W       = 4;
    localparam int DEF_RST_HOLD     = 2;

    localparam int WORD_W         = 32;
    localparam int BYTE_W         = 8;
    localparam int BYTES_PER_WORD = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LOAD    = 2'd1,
        ST_WRITE   = 2'd2,
        ST_RELEASE = 2'd3
    } loader_state_t;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

    // First byte received ends up in the top byte of the word.
    function automatic logic [WORD_W-1:0] shift_in_byte(input logic [WORD_W-1:0] word,
                                                        input logic [BYTE_W-1:0] data);
        return {word[WORD_W-BYTE_W-1:0], data};
    endfunction

endpackage

// File: rtl/sm_uart_rx.sv
// rtl/sm_uart_rx.sv - 8N1 serial receiver with mid-bit sampling
// Ports: clk, rst (async, active-high)
//        rx         - asynchronous serial line, idle high
//        byte_valid - one-cycle pulse when a byte with a good stop bit arrives
//        byte_data  - received byte, valid with byte_valid
//        frame_err  - one-cycle pulse when the stop bit is sampled low
module sm_uart_rx
    import sm_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx,
    output logic              byte_valid,
    output logic [BYTE_W-1:0] byte_data,
    output logic              frame_err
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

    logic              sync1;
    logic              line;
    logic              line_prev;
    rx_state_t         state;
    logic [CNT_W-1:0]  cnt;
    logic [2:0]        bit_idx;
    logic [BYTE_W-1:0] shreg;

    // Synchronizer plus one extra stage for falling-edge detection; all
    // reset high so a reset never looks like a start edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1     <= 1'b1;
            line      <= 1'b1;
            line_prev <= 1'b1;
        end else begin
            sync1     <= rx;
            line      <= sync1;
            line_prev <= line;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= RX_IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            byte_data  <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            case (state)
                RX_IDLE: begin
                    cnt <= '0;
                    if (line_prev && !line) begin
                        state <= RX_START;
                    end
                end
                RX_START: begin
                    if (cnt == HALF_LAST) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        // Line back high at mid-start: glitch, not a frame.
                        state   <= line ? RX_IDLE : RX_DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (cnt == BIT_LAST) begin
                        cnt   <= '0;
                        shreg <= {line, shreg[BYTE_W-1:1]};
                        if (bit_idx == 3'd7) begin
                            state <= RX_STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (cnt == BIT_LAST) begin
                        cnt   <= '0;
                        state <= RX_IDLE;
                        if (line) begin
                            byte_valid <= 1'b1;
                            byte_data  <= shreg;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= RX_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/sm_rom_loader.sv
// rtl/sm_rom_loader.sv - loads 32-bit instruction words from a UART into a ROM
// Ports: clk, rst (async, active-high)
//        uart_rx_i   - serial line, idle high
//        load_en_i   - level-sensitive load request
//        rom_we_o    - one-cycle ROM write strobe
//        rom_addr_o  - ROM word address (registered)
//        rom_wdata_o - ROM write data (registered)
//        cpu_rst_o   - holds the CPU in reset from load start until release
//        busy_o      - high whenever the loader is not idle
//        done_o      - one-cycle pulse when the loader returns to idle
//        err_o       - sticky framing / partial-word error, cleared on load start
module sm_rom_loader
    import sm_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
    parameter int ADDR_W       = DEF_ADDR_W,
    parameter int RST_HOLD     = DEF_RST_HOLD
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              uart_rx_i,
    input  logic              load_en_i,
    output logic              rom_we_o,
    output logic [ADDR_W-1:0] rom_addr_o,
    output logic [WORD_W-1:0] rom_wdata_o,
    output logic              cpu_rst_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o
);

    localparam int HOLD_W = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'((RST_HOLD > 0) ? RST_HOLD - 1 : 0);
    localparam logic [1:0] LAST_BYTE = 2'(BYTES_PER_WORD - 1);

    loader_state_t     state;
    loader_state_t     next_state;
    logic              byte_valid;
    logic [BYTE_W-1:0] byte_data;
    logic              frame_err;
    logic [1:0]        byte_idx;
    logic [WORD_W-1:0] word;
    logic [ADDR_W-1:0] addr;
    logic              err;
    logic              done_r;
    logic [HOLD_W-1:0] hold_cnt;

    sm_uart_rx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .clk        (clk),
        .rst        (rst),
        .rx         (uart_rx_i),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .frame_err  (frame_err)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (load_en_i) next_state = ST_LOAD;
            end
            ST_LOAD: begin
                // A completed word wins over load_en_i dropping in the same cycle.
                if (byte_valid && byte_idx == LAST_BYTE) next_state = ST_WRITE;
                else if (!load_en_i)                     next_state = ST_RELEASE;
            end
            ST_WRITE: begin
                next_state = load_en_i ? ST_LOAD : ST_RELEASE;
            end
            ST_RELEASE: begin
                if (hold_cnt == HOLD_LAST) next_state = ST_IDLE;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // Word assembly, address, error and hold counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            byte_idx <= '0;
            word     <= '0;
            addr     <= '0;
            err      <= 1'b0;
            done_r   <= 1'b0;
            hold_cnt <= '0;
        end else begin
            done_r <= (state == ST_RELEASE) && (next_state == ST_IDLE);
            case (state)
                ST_IDLE: begin
                    if (load_en_i) begin
                        addr     <= '0;
                        byte_idx <= '0;
                        err      <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    hold_cnt <= '0;
                    if (frame_err) err <= 1'b1;
                    if (byte_valid && (load_en_i || byte_idx == LAST_BYTE)) begin
                        word     <= shift_in_byte(word, byte_data);
                        byte_idx <= byte_idx + 2'd1;
                    end else if (!load_en_i) begin
                        // Leaving with bytes of an unfinished word: drop them.
                        if (byte_idx != 2'd0 || byte_valid) err <= 1'b1;
                        byte_idx <= '0;
                    end
                end
                ST_WRITE: begin
                    hold_cnt <= '0;
                    addr     <= addr + 1'b1;
                    byte_idx <= '0;
                    if (frame_err) err <= 1'b1;
                end
                ST_RELEASE: begin
                    hold_cnt <= hold_cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        rom_we_o    = (state == ST_WRITE);
        busy_o      = (state != ST_IDLE);
        cpu_rst_o   = (state != ST_IDLE);
        rom_addr_o  = addr;
        rom_wdata_o = word;
        done_o      = done_r;
        err_o       = err;
    end

endmodule

// File: tb/tb_sm_rom_loader.sv
// tb/tb_sm_rom_loader.sv - randomized self-checking bench for sm_rom_loader
module tb_sm_rom_loader;

    localparam int CPB = 4;
    localparam int AW  = 4;
    localparam int RH  = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          uart_rx;
    logic          load_en;
    logic          rom_we;
    logic [AW-1:0] rom_addr;
    logic [31:0]   rom_wdata;
    logic          cpu_rst;
    logic          busy;
    logic          done;
    logic          err;

    sm_rom_loader #(
        .CLKS_PER_BIT (CPB),
        .ADDR_W       (AW),
        .RST_HOLD     (RH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .uart_rx_i   (uart_rx),
        .load_en_i   (load_en),
        .rom_we_o    (rom_we),
        .rom_addr_o  (rom_addr),
        .rom_wdata_o (rom_wdata),
        .cpu_rst_o   (cpu_rst),
        .busy_o      (busy),
        .done_o      (done),
        .err_o       (err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Monitor of observed writes and pulses.
    logic [63:0] got_q[$];
    int   we_cyc   = 0;
    int   bv_cyc   = 0;
    int   done_cnt = 0;
    int   fall_cyc = 0;
    logic prev_cpu = 1'b0;

    always @(negedge clk) begin
        prev_cpu <= cpu_rst;
        if (!rst) begin
            if (rom_we) begin
                got_q.push_back((64'(rom_addr) << 32) | 64'(rom_wdata));
                we_cyc <= cyc;
            end
            if (dut.u_rx.byte_valid) bv_cyc <= cyc;
            if (done) done_cnt <= done_cnt + 1;
            if (prev_cpu && !cpu_rst) fall_cyc <= cyc;
        end
    end

    // Reference model: what a load should write, from the word-assembly rules.
    logic [63:0] exp_q[$];
    int          m_addr;
    int          m_cnt;
    logic [31:0] m_word;
    logic        m_err;
    int          drop_cyc;

    task automatic uart_byte(input logic [7:0] b, input bit stop_ok);
        logic [9:0] frame;
        frame = {stop_ok, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            uart_rx = frame[i];
            repeat (CPB) @(negedge clk);
        end
        uart_rx = 1'b1;
        repeat (2 * CPB + $urandom_range(0, CPB)) @(negedge clk);
    endtask

    task automatic start_load();
        @(negedge clk);
        load_en = 1'b1;
        m_addr  = 0;
        m_cnt   = 0;
        m_word  = '0;
        m_err   = 1'b0;
        exp_q.delete();
        repeat (3) @(negedge clk);
    endtask

    task automatic send(input logic [7:0] b, input bit ok);
        uart_byte(b, ok);
        if (ok) begin
            m_word = (m_word << 8) | 32'(b);
            m_cnt++;
            if (m_cnt == 4) begin
                exp_q.push_back((64'(m_addr) << 32) | 64'(m_word));
                m_addr = (m_addr + 1) % (1 << AW);
                m_cnt  = 0;
            end
        end else begin
            m_err = 1'b1;
        end
    endtask

    task automatic end_load();
        @(negedge clk);
        load_en  = 1'b0;
        drop_cyc = cyc;
        if (m_cnt != 0) m_err = 1'b1;
        m_cnt = 0;
        repeat (RH + 6) @(negedge clk);
    endtask

    task automatic compare_writes(input string tag, input int base);
        int n;
        n = got_q.size() - base;
        check($sformatf("%s_nwrites", tag), 64'(n), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < n; i++)
            check($sformatf("%s_write%0d", tag, i), got_q[base + i], exp_q[i]);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_we"},    64'(rom_we),    64'd0);
        check({tag, "_addr"},  64'(rom_addr),  64'd0);
        check({tag, "_wdata"}, 64'(rom_wdata), 64'd0);
        check({tag, "_cpurst"},64'(cpu_rst),   64'd0);
        check({tag, "_busy"},  64'(busy),      64'd0);
        check({tag, "_done"},  64'(done),      64'd0);
        check({tag, "_err"},   64'(err),       64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int          base;
        int          dbase;
        logic [63:0] last;

        rst     = 1'b1;
        uart_rx = 1'b1;
        load_en = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // Byte while idle is ignored.
        base = got_q.size();
        uart_byte(8'($urandom), 1'b1);
        check("idle_nowrite", 64'(got_q.size() - base), 64'd0);
        check("idle_busy", 64'(busy), 64'd0);

        // Single known word.
        base = got_q.size(); dbase = done_cnt;
        start_load();
        check("s1_cpurst", 64'(cpu_rst), 64'd1);
        send(8'h00, 1'b1); send(8'h10, 1'b1); send(8'h00, 1'b1); send(8'h73, 1'b1);
        check("s1_latency", 64'(we_cyc - bv_cyc), 64'd1);
        end_load();
        compare_writes("s1", base);
        check("s1_data", got_q[base], 64'h0000_0000_0010_0073);
        check("s1_done", 64'(done_cnt - dbase), 64'd1);
        check("s1_err", 64'(err), 64'(m_err));

        // 16 random words fill the ROM.
        base = got_q.size(); dbase = done_cnt;
        start_load();
        for (int w = 0; w < 16; w++)
            for (int b = 0; b < 4; b++) send(8'($urandom), 1'b1);
        end_load();
        compare_writes("s2", base);
        check("s2_rst_fall", 64'(fall_cyc), 64'(drop_cyc + 1 + RH));
        check("s2_done", 64'(done_cnt - dbase), 64'd1);
        check("s2_err", 64'(err), 64'd0);
        check("s2_busy", 64'(busy), 64'd0);

        // 17 words: the last wraps to address 0.
        base = got_q.size(); dbase = done_cnt;
        start_load();
        for (int w = 0; w < 17; w++)
            for (int b = 0; b < 4; b++) send(8'($urandom), 1'b1);
        end_load();
        compare_writes("s3", base);
        last = got_q[got_q.size() - 1];
        check("s3_wrap_addr", 64'(last[35:32]), 64'd0);
        check("s3_done", 64'(done_cnt - dbase), 64'd1);

        // Partial word then release.
        base = got_q.size();
        start_load();
        send(8'($urandom), 1'b1); send(8'($urandom), 1'b1);
        end_load();
        compare_writes("s4", base);
        check("s4_err", 64'(err), 64'(m_err));
        start_load();
        check("s4_err_cleared", 64'(err), 64'd0);
        end_load();
        check("s4_err_after_empty", 64'(err), 64'd0);

        // Framing error, then a clean word from good bytes only.
        base = got_q.size();
        start_load();
        send(8'($urandom), 1'b0);
        check("s5_err_frame", 64'(err), 64'(m_err));
        for (int b = 0; b < 4; b++) send(8'($urandom), 1'b1);
        end_load();
        compare_writes("s5", base);
        check("s5_err_sticky", 64'(err), 64'(m_err));

        // Reset in the middle of a word.
        start_load();
        for (int b = 0; b < 3; b++) send(8'($urandom | 32'h1), 1'b1);
        @(negedge clk);
        rst     = 1'b1;
        load_en = 1'b0;
        #1;
        check_all_zero("s6_rst");
        base = got_q.size(); dbase = done_cnt;
        @(negedge clk);
        rst = 1'b0;
        repeat (60) @(negedge clk);
        check("s6_nowrite", 64'(got_q.size() - base), 64'd0);
        check("s6_nodone", 64'(done_cnt - dbase), 64'd0);
        start_load();
        for (int b = 0; b < 4; b++) send(8'($urandom), 1'b1);
        end_load();
        compare_writes("s6", base);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/sm_rom_loader.md
SM_ROM_LOADER -- requirements
Module: sm_rom_loader

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 870, meaning system clocks per UART bit (8N1).
REQ-002 SHALL have parameter ADDR_W, default 4, meaning instruction-ROM word-address width (16 words).
REQ-003 SHALL have parameter RST_HOLD, default 2, meaning cycles the CPU reset is held after the load ends.
REQ-004 SHALL have port clk, input, 1, the single system clock; all state is on its rising edge.
REQ-005 SHALL have port rst, input, 1, reset; asynchronous, active-high.
REQ-006 SHALL have port uart_rx_i, input, 1, asynchronous serial line (idle high).
REQ-007 SHALL have port load_en_i, input, 1, load request; level-sensitive, from romWrite.
REQ-008 SHALL have port rom_we_o, output, 1, ROM write strobe.
REQ-009 SHALL have port rom_addr_o, output, ADDR_W, ROM word address.
REQ-010 SHALL have port rom_wdata_o, output, 32, ROM write data.
REQ-011 SHALL have port cpu_rst_o, output, 1, active-high hold-in-reset for the CPU.
REQ-012 SHALL have port busy_o, output, 1, high in any state other than IDLE.
REQ-013 SHALL have port done_o, output, 1, one-cycle pulse at load completion.
REQ-014 SHALL have port err_o, output, 1, sticky framing or partial-word error.

Function
REQ-015 SHALL use FSM states IDLE, LOAD, WRITE and RELEASE.
REQ-016 IDLE->LOAD SHALL occur on the first cycle load_en_i=1; on that transition it SHALL clear the address, byte index and err_o, and set cpu_rst_o=1.
REQ-017 In LOAD, each valid received byte SHALL shift in MSB-first (word={word[23:0],byte}) and the byte index (0..3) SHALL increment.
REQ-018 On the 4th byte the FSM SHALL go to WRITE; rom_we_o=1 for exactly one cycle, asserted 1 cycle after the 4th byte-valid, with the current address and the assembled word.
REQ-019 After WRITE, the address SHALL increment modulo 2^ADDR_W (15->0 wrap, overwriting) and the FSM SHALL return to LOAD with the byte index set to 0.
REQ-020 Deassertion of load_en_i in LOAD SHALL cause LOAD->RELEASE; a nonzero byte index at that point SHALL discard the partial word and set err_o.
REQ-021 If the 4th byte-valid coincides with load_en_i falling, the write SHALL still occur (WRITE), then RELEASE without error.
REQ-022 RELEASE SHALL keep cpu_rst_o=1 for RST_HOLD cycles, then go to IDLE with cpu_rst_o=0 and done_o pulsed for 1 cycle.
REQ-023 load_en_i reasserted during RELEASE SHALL be ignored until IDLE.
REQ-024 Receiver: 2-FF synchronizer; start detected on a falling edge and confirmed low at mid-bit (CLKS_PER_BIT/2); 8 data bits LSB-first each sampled at mid-bit; stop bit sampled at mid-bit.
REQ-025 A stop bit sampled 0 SHALL drop the byte (no byte-valid) and set err_o; a false start (high at mid-start) SHALL return the receiver to idle silently.
REQ-026 Bytes arriving while the FSM is in IDLE or RELEASE SHALL be ignored.
REQ-027 rom_addr_o and rom_wdata_o SHALL be registered and stable while rom_we_o=1.

Reset
REQ-028 rst=1 SHALL asynchronously force: FSM IDLE, receiver idle, rom_we_o=0, rom_addr_o=0, rom_wdata_o=0, cpu_rst_o=0, busy_o=0, done_o=0, err_o=0.
REQ-029 Reset mid-load SHALL abandon the load, with no further write and no done_o.

Structure
REQ-030 FSM state encoding and the default parameter constants SHALL reside in the shared package sm_loader_pkg.
REQ-031 The serial receiver SHALL be the sub-module sm_uart_rx (outputs: byte_valid one-cycle pulse, byte data, frame_err pulse); FSM and word assembly SHALL be in sm_rom_loader.

Verification
REQ-032 Bench SHALL run with CLKS_PER_BIT=4 and cover: load_en=1, bytes 00,10,00,73 -> one rom_we_o with addr 0 and data 0x00100073, one cycle after the 4th byte-valid.
REQ-033 Bench SHALL cover: 16 words, then load_en=0 -> addresses 0..15 written in order, cpu_rst_o falls exactly RST_HOLD=2 cycles after RELEASE entry, one done_o pulse, err_o=0.
REQ-034 Bench SHALL cover: 17 words -> the 17th write goes to addr 0.
REQ-035 Bench SHALL cover: 2 bytes then load_en=0 -> no write and err_o=1; a following load start clears err_o.
REQ-036 Bench SHALL cover: a byte with stop bit 0 -> no byte-valid and err_o=1; the next valid 4 bytes form a word from good bytes only.
REQ-037 Bench SHALL cover: rst pulsed after 3 bytes -> all outputs 0 immediately; a new load writes from addr 0.
